// File: rtl/cic_sample_scheduler.sv
// Sequencer and output buffer for the CIC decimator: strobe generation from a phase
// accumulator, bit-stream capture, CIC enable/clear, warm-up discard and a small FWFT FIFO.
module cic_sample_scheduler #(
  parameter int unsigned PHASE_W   = 32,
  parameter int unsigned PHASE_INC = 43980465,
  parameter int unsigned DEC_R     = 64,
  parameter int unsigned DW        = 64,
  parameter int unsigned WARMUP_N  = 4,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          bit_in,
  output logic          cic_clr,
  output logic          cic_en,
  output logic          cic_bit,
  input  logic [DW-1:0] cic_dout,
  input  logic          cic_rdy,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam int unsigned DecW  = (DEC_R > 1) ? $clog2(DEC_R) : 1;
  localparam int unsigned WarmW = (WARMUP_N > 1) ? $clog2(WARMUP_N) : 1;

  localparam logic [PHASE_W-1:0] IncVal   = PHASE_W'(PHASE_INC);
  localparam logic [DecW-1:0]    DecLast  = DecW'(DEC_R - 1);
  localparam logic [WarmW-1:0]   WarmLast = WarmW'(WARMUP_N - 1);

  typedef enum logic [1:0] {StIdle, StClear, StWarmup, StRun} state_e;

  state_e             state_q;
  logic [PHASE_W-1:0] acc_q;
  logic [DecW-1:0]    dec_cnt_q;
  logic [WarmW-1:0]   warm_cnt_q;
  logic               cic_clr_q, cic_en_q, cic_bit_q, overflow_q;
  logic               bit_s1_q, bit_s2_q;

  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [DW-1:0]      mem_q [Depth];

  logic               active;
  logic [PHASE_W:0]   acc_sum;
  logic               fifo_empty, fifo_full;
  logic               rd_en, wr_en, rdy_run, flush;

  assign active     = (state_q == StWarmup) || (state_q == StRun);
  assign acc_sum    = {1'b0, acc_q} + {1'b0, IncVal};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(Depth));
  assign rd_en      = !fifo_empty && m_ready;
  assign rdy_run    = (state_q == StRun) && cic_rdy;
  // A read in the same cycle frees the slot, so a full FIFO can still accept the write
  assign wr_en      = rdy_run && (!fifo_full || rd_en);
  // Entering CLEAR resets all per-conversion state, including the buffer
  assign flush      = (state_q == StIdle) && start;

  // Two-flop synchronizer for the asynchronous modulator stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_s1_q <= 1'b0;
      bit_s2_q <= 1'b0;
    end else begin
      bit_s1_q <= bit_in;
      bit_s2_q <= bit_s1_q;
    end
  end

  // Control FSM with phase accumulator, strobe and warm-up/decimation counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      dec_cnt_q  <= '0;
      warm_cnt_q <= '0;
      cic_clr_q  <= 1'b0;
      cic_en_q   <= 1'b0;
      cic_bit_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cic_clr_q <= 1'b0;
      cic_en_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StClear;
            cic_clr_q  <= 1'b1;
            acc_q      <= '0;
            dec_cnt_q  <= '0;
            warm_cnt_q <= '0;
            overflow_q <= 1'b0;
          end
        end
        StClear: begin
          if (stop) begin
            state_q <= StIdle;
          end else if (WARMUP_N == 0) begin
            state_q <= StRun;
          end else begin
            state_q <= StWarmup;
          end
        end
        StWarmup: begin
          if (stop) begin
            state_q <= StIdle;
          end else if (cic_rdy) begin
            // Settling outputs are counted and dropped
            if (warm_cnt_q == WarmLast) begin
              state_q <= StRun;
            end else begin
              warm_cnt_q <= warm_cnt_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (stop) begin
            state_q <= StIdle;
          end
          if (rdy_run && fifo_full && !rd_en) begin
            overflow_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Accumulator runs only while converting; it freezes in IDLE
      if (active) begin
        acc_q <= acc_sum[PHASE_W-1:0];
        if (acc_sum[PHASE_W]) begin
          cic_en_q  <= 1'b1;
          cic_bit_q <= bit_s2_q;
          dec_cnt_q <= (dec_cnt_q == DecLast) ? '0 : dec_cnt_q + 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // FIFO storage; contents need no reset since the head is gated by occupancy
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= cic_dout;
    end
  end

  assign cic_clr  = cic_clr_q;
  assign cic_en   = cic_en_q;
  assign cic_bit  = cic_bit_q;
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign busy     = (state_q != StIdle);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cic_sample_scheduler.sv
// Bench for cic_sample_scheduler: directed sequence with random bits/data, checked every
// cycle against a queue-based behavioural model.
module tb_cic_sample_scheduler;

  localparam int unsigned PHASE_W   = 32;
  localparam int unsigned PHASE_INC = 32'h1000_0000;
  localparam int unsigned DEC_R     = 64;
  localparam int unsigned DW        = 64;
  localparam int unsigned WARMUP_N  = 4;
  localparam int unsigned FIFO_AW   = 2;
  localparam int          DEPTH     = 4;
  localparam int          HistN     = 1024;
  localparam longint unsigned Inc64 = PHASE_INC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, bit_in = 1'b0, cic_rdy = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] cic_dout = '0;
  logic          cic_clr, cic_en, cic_bit, m_valid, busy, overflow;
  logic [DW-1:0] m_data;

  int n_cmp = 0;
  int n_err = 0;

  cic_sample_scheduler #(
    .PHASE_W  (PHASE_W),
    .PHASE_INC(PHASE_INC),
    .DEC_R    (DEC_R),
    .DW       (DW),
    .WARMUP_N (WARMUP_N),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .bit_in  (bit_in),
    .cic_clr (cic_clr),
    .cic_en  (cic_en),
    .cic_bit (cic_bit),
    .cic_dout(cic_dout),
    .cic_rdy (cic_rdy),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .overflow(overflow)
  );

  always #10 clk = ~clk;

  // Behavioural model state
  typedef enum int {MIdle, MClear, MWarm, MRun} mstate_e;
  mstate_e         ms = MIdle;
  logic [DW-1:0]   q[$];
  int              warm = 0;
  longint unsigned t = 0;
  bit              exp_en = 1'b0, exp_bit = 1'b0, exp_ovf = 1'b0;
  bit              hist[HistN];
  int              cyc = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cic_clr", cic_clr, ms == MClear);
    chk("cic_en", cic_en, exp_en);
    chk("cic_bit", cic_bit, exp_bit);
    chk("m_valid", m_valid, q.size() != 0);
    chk("m_data", m_data, (q.size() != 0) ? q[0] : '0);
    chk("busy", busy, ms != MIdle);
    chk("overflow", overflow, exp_ovf);
  endtask

  // One clock cycle: advance the model from the inputs present at the edge, then compare
  task automatic step();
    bit            act, rd, do_flush;
    mstate_e       nxt;
    logic [DW-1:0] d, junk;
    hist[(cyc + 1) % HistN] = bit_in;
    act      = (ms == MWarm) || (ms == MRun);
    rd       = (q.size() != 0) && m_ready;
    do_flush = (ms == MIdle) && start;
    d        = cic_dout;
    nxt      = ms;
    case (ms)
      MIdle:  if (start) nxt = MClear;
      MClear: nxt = stop ? MIdle : ((WARMUP_N == 0) ? MRun : MWarm);
      MWarm:  if (stop) nxt = MIdle;
              else if (cic_rdy && (warm + 1 == int'(WARMUP_N))) nxt = MRun;
      MRun:   if (stop) nxt = MIdle;
      default: nxt = MIdle;
    endcase
    @(posedge clk);
    cyc++;
    if (do_flush) begin
      q.delete();
      exp_ovf = 1'b0;
      t       = 0;
      warm    = 0;
    end else begin
      if (rd) junk = q.pop_front();
      if (ms == MRun && cic_rdy) begin
        if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf = 1'b1;
      end
      if (ms == MWarm && cic_rdy) warm++;
    end
    exp_en = 1'b0;
    if (act) begin
      t++;
      exp_en = ((t * Inc64) >> PHASE_W) != (((t - 1) * Inc64) >> PHASE_W);
      if (exp_en) exp_bit = hist[(cyc - 2) % HistN];
    end
    ms = nxt;
    #1;
    check_all();
    bit_in = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic rdy_pulse(input logic [DW-1:0] d);
    cic_rdy  = 1'b1;
    cic_dout = d;
    step();
    cic_rdy  = 1'b0;
    cic_dout = {$urandom, $urandom};
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic apply_reset();
    #3 rst = 1'b0;
    #1;
    ms = MIdle; q.delete(); warm = 0; t = 0;
    exp_en = 1'b0; exp_bit = 1'b0; exp_ovf = 1'b0;
    check_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] w;
    apply_reset();

    // Start: single clear pulse, then a strobe every 16 clocks with delayed bit capture
    start = 1'b1; step(); start = 1'b0;
    chk("clr_pulse", cic_clr, 1);
    step();
    chk("clr_single", cic_clr, 0);
    idle_cycles(40);

    // Warm-up: first four results dropped, 5 and 6 buffered
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      rdy_pulse(DW'(i));
      idle_cycles($urandom_range(0, 2));
    end
    chk("warm_head", m_data, 5);
    chk("warm_valid", m_valid, 1);
    m_ready = 1'b1; idle_cycles(3); m_ready = 1'b0;
    chk("warm_drained", m_valid, 0);

    // Fill to full, then write and read in the same cycle
    for (int i = 0; i < 4; i++) rdy_pulse({$urandom, $urandom});
    chk("full_no_ovf", overflow, 0);
    m_ready = 1'b1; rdy_pulse({$urandom, $urandom}); m_ready = 1'b0;
    chk("simul_no_ovf", overflow, 0);
    chk("simul_valid", m_valid, 1);

    // Write into a full FIFO without a read: dropped and sticky overflow
    rdy_pulse({$urandom, $urandom});
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 10; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1; idle_cycles(4); m_ready = 1'b0;
    chk("drain_empty", m_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Stop with a word buffered: strobes stop, word survives into IDLE
    w = 64'hFFFF_FFFF_FFFF_FFFE;
    rdy_pulse(w);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    idle_cycles(40);
    chk("stop_word", m_data, 64'hFFFF_FFFF_FFFF_FFFE);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    chk("stop_read", m_valid, 0);

    // start and stop together in IDLE: start wins
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_wins", busy, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      rdy_pulse({$urandom, $urandom});
      idle_cycles(1);
    end
    rdy_pulse({$urandom, $urandom});
    rdy_pulse({$urandom, $urandom});
    idle_cycles(3);
    chk("pre_reset_valid", m_valid, 1);
    apply_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);

    // Random traffic across all states
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      cic_rdy  = ($urandom_range(0, 3) == 0);
      cic_dout = {$urandom, $urandom};
      m_ready  = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0; stop = 1'b0; cic_rdy = 1'b0; m_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
